// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_pkg
// Description : Shared types and sizing helpers for the shift-and-add
//               multiplier (controller state type, counter/product widths).
// Revision    : 1.0 - initial release
// ============================================================================
package mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Iteration counter width: must hold 0 .. WIDTH-1.
    function automatic int cnt_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

    // Full product width.
    function automatic int prod_width(input int width);
        return 2 * width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/shift_add_mult_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : shift_add_mult_ctrl
// Description : Sequencer for the shift-and-add multiplier. Owns the
//               IDLE/CALC/FIX/DONE state machine and the iteration counter,
//               and issues load/step/fix strobes to the datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_add_mult_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic last_hint,   // datapath says the remaining multiplier is zero
    output logic load,
    output logic step,
    output logic fix,
    output logic busy,
    output logic done
);

    localparam int                CNT_W      = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]  C_CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    // State and iteration counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic and datapath strobes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        step    = 1'b0;
        fix     = 1'b0;
        busy    = (state_q == ST_CALC) || (state_q == ST_FIX);
        done    = (state_q == ST_DONE);
        case (state_q)
            ST_IDLE, ST_DONE: begin
                // DONE accepts a new start directly so results can stream.
                if (start) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_CALC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                step  = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if ((cnt_q == C_CNT_LAST) || last_hint) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                fix     = 1'b1;
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/shift_add_mult.sv
`default_nettype none
// ============================================================================
// Module      : shift_add_mult
// Description : Sequential WIDTH x WIDTH shift-and-add multiplier with a
//               2*WIDTH product, per-operation signed/unsigned mode and a
//               start/done handshake. Signed operands are multiplied as
//               magnitudes and the sign is applied in a final FIX cycle.
//               Optional macro MULT_EARLY_TERM_EN: leave CALC as soon as
//               the remaining multiplier bits are all zero.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_add_mult
    import mult_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  start,
    input  logic                  mode_signed,
    input  logic [WIDTH-1:0]      operand_a,
    input  logic [WIDTH-1:0]      operand_b,
    output logic                  busy,
    output logic                  done,
    output logic [2*WIDTH-1:0]    product
);

    localparam int PW = prod_width(WIDTH);

    logic          w_load, w_step, w_fix, w_last_hint;
    logic          w_a_neg, w_b_neg;
    logic [WIDTH-1:0] w_a_mag, w_b_mag;

    logic [PW-1:0]    mcand_q,    mcand_d;
    logic [WIDTH-1:0] mplier_q,   mplier_d;
    logic [PW-1:0]    acc_q,      acc_d;
    logic             sign_neg_q, sign_neg_d;
    logic [PW-1:0]    product_q,  product_d;

    shift_add_mult_ctrl #(
        .WIDTH     (WIDTH)
    ) u_ctrl (
        .clk       (sys_clk),
        .rst       (sys_rst),
        .start     (start),
        .last_hint (w_last_hint),
        .load      (w_load),
        .step      (w_step),
        .fix       (w_fix),
        .busy      (busy),
        .done      (done)
    );

    // Operand magnitudes; -2^(WIDTH-1) maps to 2^(WIDTH-1), which fits unsigned.
    assign w_a_neg = mode_signed & operand_a[WIDTH-1];
    assign w_b_neg = mode_signed & operand_b[WIDTH-1];
    assign w_a_mag = w_a_neg ? (~operand_a + 1'b1) : operand_a;
    assign w_b_mag = w_b_neg ? (~operand_b + 1'b1) : operand_b;

`ifdef MULT_EARLY_TERM_EN
    // Multiplier bits still to be consumed after this cycle's shift are zero.
    assign w_last_hint = (mplier_q[WIDTH-1:1] == '0);
`else
    assign w_last_hint = 1'b0;
`endif

    // Datapath registers.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            mcand_q    <= '0;
            mplier_q   <= '0;
            acc_q      <= '0;
            sign_neg_q <= 1'b0;
            product_q  <= '0;
        end else begin
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            acc_q      <= acc_d;
            sign_neg_q <= sign_neg_d;
            product_q  <= product_d;
        end
    end

    // Load operands, accumulate shifted multiplicand, apply sign at the end.
    always_comb begin
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        acc_d      = acc_q;
        sign_neg_d = sign_neg_q;
        product_d  = product_q;
        if (w_load) begin
            sign_neg_d = mode_signed & (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
            mcand_d    = {{WIDTH{1'b0}}, w_a_mag};
            mplier_d   = w_b_mag;
            acc_d      = '0;
        end else if (w_step) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
        end else if (w_fix) begin
            product_d = sign_neg_q ? (~acc_q + 1'b1) : acc_q;
        end
    end

    assign product = product_q;

endmodule
`default_nettype wire
